rs_error_corrector: RTL and testbench

- Final stage of the RS(255,239) decoder, directly downstream of the Forney error-value stage.
- Buffers each received n-symbol frame in a two-bank ping-pong RAM while syndrome, BM, Chien and Forney run.
- Replays the frame in lockstep with the per-symbol error strobe, XORs the error magnitude into flagged positions, and emits the corrected stream with framing and a decode-failure verdict.

---
 rtl/rs_error_corrector.sv | 214 +++++++++++++++++++++
 tb/tb_rs_error_corrector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rs_error_corrector.sv
// Final RS(255,239) decoder stage: ping-pong frame buffer replayed against Forney error values.
// Optional statistics counters are enabled by defining RS_ERR_STATS_EN.
module rs_error_corrector #(
    parameter int N = 255,
    parameter int T = 8,
    parameter int M = 8
) (
    input  logic         clk_in,
    input  logic         sys_rst_n,
    input  logic         din_valid,
    input  logic         din_sop,
    input  logic [M-1:0] din,
    input  logic         err_valid,
    input  logic         err_loc,
    input  logic [M-1:0] err_val,
    input  logic [3:0]   lambda_deg,
    output logic         dout_valid,
    output logic         dout_sop,
    output logic         dout_eop,
    output logic [M-1:0] dout,
    output logic [3:0]   err_cnt,
    output logic         decode_fail,
    output logic         overflow,
`ifdef RS_ERR_STATS_EN
    output logic [15:0]  frames_ok,
    output logic [15:0]  frames_fail,
    output logic [23:0]  sym_corrected,
`endif
    output logic         protocol_err
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CORRECT = 2'd1, S_DONE = 2'd2} state_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

`ifdef RS_ERR_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [23:0] sat_add24(input logic [23:0] a, input logic [3:0] b);
        logic [24:0] s;
        s = {1'b0, a} + 25'(b);
        return s[24] ? 24'hFF_FFFF : s[23:0];
    endfunction
`endif

    logic [M-1:0]  r_mem [0:(2**(AW+1))-1];
    logic [M-1:0]  r_ram_q, r_val_p1;
    logic          r_loc_p1, r_vld_p1, r_sop_p1, r_eop_p1;
    logic          r_wr_active, r_wbank, r_oldest, r_rbank;
    logic [AW-1:0] r_waddr, r_raddr;
    logic [1:0]    r_full;
    logic [3:0]    r_lambda, r_count;
    state_t        r_state, w_next;

    logic          w_start, w_rd_en, w_free, w_full_any, w_sel_bank, w_rd_bank;
    logic [AW-1:0] w_rd_addr, w_waddr;
    logic [1:0]    w_empty;
    logic          w_open, w_ovf, w_we, w_wbank, w_wdone, w_fail;

    // A bank being freed this cycle already counts as empty for a new frame.
    assign w_empty    = ~r_full | ({1'b0, w_free} << r_rbank);
    assign w_open     = din_valid & din_sop & ~r_wr_active & (|w_empty);
    assign w_ovf      = din_valid & din_sop & ~r_wr_active & ~(|w_empty);
    assign w_we       = w_open | (din_valid & r_wr_active);
    assign w_wbank    = w_open ? (w_empty[~r_rbank] ? ~r_rbank : r_rbank) : r_wbank;
    assign w_waddr    = din_sop ? '0 : r_waddr;
    assign w_wdone    = w_we & (w_waddr == LAST);

    assign w_full_any = |r_full;
    assign w_sel_bank = (&r_full) ? r_oldest : r_full[1];
    assign w_rd_bank  = w_start ? w_sel_bank : r_rbank;
    assign w_rd_addr  = w_start ? '0 : r_raddr;
    assign w_fail     = (r_count != r_lambda) | (r_lambda > 4'(T));

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_active <= 1'b0;
            r_wbank     <= 1'b0;
            r_waddr     <= '0;
            r_full      <= 2'b00;
            r_oldest    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (w_we) begin
                r_wbank     <= w_wbank;
                r_waddr     <= w_waddr + 1'b1;
                r_wr_active <= ~w_wdone;
            end
            if (w_ovf)
                overflow <= 1'b1;
            if (w_free)
                r_full[r_rbank] <= 1'b0;
            if (w_wdone) begin
                r_full[w_wbank] <= 1'b1;
                if (w_empty[~w_wbank])
                    r_oldest <= w_wbank;
            end
        end
    end

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (err_valid && w_full_any) w_next = S_CORRECT;
            S_CORRECT: if (err_valid && r_raddr == LAST) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start = 1'b0;
        w_rd_en = 1'b0;
        w_free  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start = err_valid & w_full_any;
                w_rd_en = err_valid & w_full_any;
            end
            S_CORRECT: w_rd_en = err_valid;
            S_DONE:    w_free  = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rbank      <= 1'b0;
            r_raddr      <= '0;
            r_lambda     <= 4'd0;
            r_count      <= 4'd0;
            protocol_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_rbank  <= w_sel_bank;
                r_lambda <= lambda_deg;
                r_count  <= {3'b000, err_loc};
            end else if (w_rd_en && err_loc) begin
                r_count  <= sat_inc4(r_count);
            end
            if (w_rd_en)
                r_raddr <= w_rd_addr + 1'b1;
            if (r_state == S_IDLE && err_valid && !w_full_any)
                protocol_err <= 1'b1;
        end
    end

    // Stage p1: RAM read and error-term alignment
    always_ff @(posedge clk_in) begin
        if (w_we)
            r_mem[{w_wbank, w_waddr}] <= din;
        r_ram_q  <= r_mem[{w_rd_bank, w_rd_addr}];
        r_loc_p1 <= err_loc;
        r_val_p1 <= err_val;
    end

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_vld_p1 <= 1'b0;
            r_sop_p1 <= 1'b0;
            r_eop_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_rd_en;
            r_sop_p1 <= w_rd_en & (w_rd_addr == '0);
            r_eop_p1 <= w_rd_en & (w_rd_addr == LAST);
        end
    end

    // Stage p2: correction and output register
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dout_valid    <= 1'b0;
            dout_sop      <= 1'b0;
            dout_eop      <= 1'b0;
            dout          <= '0;
            err_cnt       <= 4'd0;
            decode_fail   <= 1'b0;
`ifdef RS_ERR_STATS_EN
            frames_ok     <= 16'd0;
            frames_fail   <= 16'd0;
            sym_corrected <= 24'd0;
`endif
        end else begin
            dout_valid  <= r_vld_p1;
            dout_sop    <= r_sop_p1;
            dout_eop    <= r_eop_p1;
            decode_fail <= r_eop_p1 & w_fail;
            if (r_vld_p1)
                dout <= r_ram_q ^ (r_loc_p1 ? r_val_p1 : '0);
            if (r_eop_p1) begin
                err_cnt <= r_count;
`ifdef RS_ERR_STATS_EN
                if (w_fail) begin
                    frames_fail   <= sat_inc16(frames_fail);
                end else begin
                    frames_ok     <= sat_inc16(frames_ok);
                    sym_corrected <= sat_add24(sym_corrected, r_count);
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_rs_error_corrector.sv
// Directed bench for rs_error_corrector: clean, corrected, failing, overflow, gapped and reset frames.
module tb_rs_error_corrector;
    localparam int N = 255;

    logic       clk_in = 1'b0;
    logic       sys_rst_n, din_valid, din_sop, err_valid, err_loc;
    logic [7:0] din, err_val, dout;
    logic [3:0] lambda_deg, err_cnt;
    logic       dout_valid, dout_sop, dout_eop, decode_fail, overflow, protocol_err;
`ifdef RS_ERR_STATS_EN
    logic [15:0] frames_ok, frames_fail;
    logic [23:0] sym_corrected;
`endif

    rs_error_corrector dut (
        .clk_in(clk_in), .sys_rst_n(sys_rst_n),
        .din_valid(din_valid), .din_sop(din_sop), .din(din),
        .err_valid(err_valid), .err_loc(err_loc), .err_val(err_val), .lambda_deg(lambda_deg),
        .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout(dout),
        .err_cnt(err_cnt), .decode_fail(decode_fail), .overflow(overflow),
`ifdef RS_ERR_STATS_EN
        .frames_ok(frames_ok), .frames_fail(frames_fail), .sym_corrected(sym_corrected),
`endif
        .protocol_err(protocol_err)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0, n_pass = 0, cyc = 0, t0 = 0;
    logic [7:0] q[$];
    int sop_idx = -1, eop_idx = -1, sop_cyc = -1, stray = 0;
    logic [3:0] cnt_eop = 4'd0;
    logic       fail_eop = 1'b0;
    int         epos[$];
    logic [7:0] eval_q[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (dout_valid) begin
            if (dout_sop) begin sop_idx = q.size(); sop_cyc = cyc; end
            if (dout_eop) begin eop_idx = q.size(); cnt_eop = err_cnt; fail_eop = decode_fail; end
            q.push_back(dout);
        end
        if (decode_fail && !dout_eop) stray++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [7:0] exp_sym(input int f, input int i);
        logic [7:0] s;
        s = 8'((i + f * 37) & 255);
        foreach (epos[j]) if (epos[j] == i) s ^= eval_q[j];
        return s;
    endfunction

    task automatic clear_mon();
        q.delete();
        sop_idx = -1; eop_idx = -1; sop_cyc = -1; stray = 0;
    endtask

    task automatic write_frame(input int f);
        for (int i = 0; i < N; i++) begin
            din_valid = 1'b1;
            din_sop   = (i == 0);
            din       = 8'((i + f * 37) & 255);
            step();
        end
        din_valid = 1'b0;
        din_sop   = 1'b0;
        step();
    endtask

    task automatic drive_strobes(input int lam, input int gap, input int nsym);
        for (int i = 0; i < nsym; i++) begin
            int hit;
            hit = -1;
            foreach (epos[j]) if (epos[j] == i) hit = j;
            err_valid  = 1'b1;
            err_loc    = (hit >= 0);
            err_val    = (hit >= 0) ? eval_q[hit] : 8'($urandom);
            lambda_deg = (i == 0) ? 4'(lam) : ~4'(lam);
            if (i == 0) t0 = cyc;
            step();
            err_valid = 1'b0;
            err_loc   = 1'b0;
            repeat (gap) step();
        end
    endtask

    task automatic replay(input int lam, input int gap);
        clear_mon();
        drive_strobes(lam, gap, N);
        repeat (6) step();
    endtask

    task automatic verify(input string tag, input int f, input int want_cnt, input logic want_fail);
        int nbad;
        nbad = 0;
        foreach (q[i]) if (q[i] !== exp_sym(f, i)) nbad++;
        check({tag, "_len"},   q.size(), N);
        check({tag, "_data"},  nbad, 0);
        check({tag, "_sop"},   sop_idx, 0);
        check({tag, "_eop"},   eop_idx, N - 1);
        check({tag, "_lat"},   sop_cyc - t0, 2);
        check({tag, "_cnt"},   cnt_eop, want_cnt);
        check({tag, "_fail"},  fail_eop, want_fail);
        check({tag, "_stray"}, stray, 0);
    endtask

    initial begin
        sys_rst_n = 1'b0; din_valid = 1'b0; din_sop = 1'b0; din = 8'd0;
        err_valid = 1'b0; err_loc = 1'b0; err_val = 8'd0; lambda_deg = 4'd0;
        repeat (3) step();
        sys_rst_n = 1'b1;
        step();
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_decode_fail", decode_fail, 0);
        check("rst_overflow", overflow, 0);
        check("rst_protocol_err", protocol_err, 0);

        // strobe with nothing buffered
        clear_mon();
        err_valid = 1'b1; err_loc = 1'b1;
        step();
        err_valid = 1'b0; err_loc = 1'b0;
        repeat (4) step();
        check("perr_set", protocol_err, 1);
        check("perr_no_dout", q.size(), 0);

        epos.delete(); eval_q.delete();
        write_frame(0);
        replay(0, 0);
        verify("clean", 0, 0, 1'b0);

        epos = '{5, 100, 254}; eval_q = '{8'h3C, 8'h01, 8'hFF};
        write_frame(1);
        replay(3, 0);
        verify("err3", 1, 3, 1'b0);
        check("err3_sym5", q[5], 8'h16);
        check("err3_sym100", q[100], 8'h88);
        check("err3_sym254", q[254], 8'hDC);
        check("err3_sym6", q[6], 8'h2B);

        epos = '{10, 20}; eval_q = '{8'h55, 8'hAA};
        write_frame(2);
        replay(3, 0);
        verify("mismatch", 2, 2, 1'b1);

        epos = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        eval_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        write_frame(3);
        replay(9, 0);
        verify("lam9", 3, 9, 1'b1);
        check("lam9_sym0", q[0], 8'h6E);

        epos.delete(); eval_q.delete();
        write_frame(4);
        write_frame(5);
        check("ovf_pre", overflow, 0);
        write_frame(6);
        check("ovf_set", overflow, 1);
        replay(0, 0);
        verify("b2b_first", 4, 0, 1'b0);
        replay(0, 2);
        verify("b2b_second_gap", 5, 0, 1'b0);

        write_frame(7);
        clear_mon();
        drive_strobes(0, 0, 121);
        check("mid_active", dout_valid, 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("arst_dout_valid", dout_valid, 0);
        check("arst_dout", dout, 0);
        check("arst_overflow", overflow, 0);
        check("arst_protocol_err", protocol_err, 0);
        step(); step();
        sys_rst_n = 1'b1;
        step();

        epos = '{254}; eval_q = '{8'h80};
        write_frame(8);
        replay(1, 0);
        verify("post_rst", 8, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
